// File: rtl/rtc_bus_pkg.sv
// Shared types and default timing for the RTC bus master: FSM state encoding
// and the default phase lengths used as parameter defaults.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASU,
    ST_APW,
    ST_AH,
    ST_GAP,
    ST_DPW,
    ST_DH,
    ST_DONE
  } state_t;

  localparam int DEF_DW        = 8;
  localparam int DEF_T_ASU     = 1;
  localparam int DEF_T_APW     = 6;
  localparam int DEF_T_AH      = 2;
  localparam int DEF_T_GAP     = 10;
  localparam int DEF_T_DPW     = 6;
  localparam int DEF_T_DH      = 2;
  localparam int DEF_MAX_BURST = 8;

  // Wide enough for any practical phase length.
  localparam int TIMER_W = 16;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that stops at zero; zero marks the last cycle of a
// timed phase when loaded with (phase length - 1) on phase entry.
module phase_timer
  import rtc_bus_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  // NOTE: clocked state is always written with <= so every flop samples the
  // pre-edge value of its neighbours regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rtc_bus_master.sv
// Multiplexed-bus master for an RTC: address phase, gap, then data phase.
// Define BURST_EN to enable multi-word bursts with auto-incrementing address.
module rtc_bus_master
  import rtc_bus_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int T_ASU     = DEF_T_ASU,
  parameter int T_APW     = DEF_T_APW,
  parameter int T_AH      = DEF_T_AH,
  parameter int T_GAP     = DEF_T_GAP,
  parameter int T_DPW     = DEF_T_DPW,
  parameter int T_DH      = DEF_T_DH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             write,
  input  logic [DW-1:0]                    addr,
  input  logic [DW-1:0]                    wdata,
  input  logic [$clog2(MAX_BURST+1)-1:0]   burst_len,
  input  logic [DW-1:0]                    bus_in,
  output logic [DW-1:0]                    bus_out,
  output logic                             bus_oe,
  output logic                             cs_n,
  output logic                             ad_n,
  output logic                             rd_n,
  output logic                             wr_n,
  output logic [DW-1:0]                    rdata,
  output logic                             rdata_valid,
  output logic                             wdata_req,
  output logic                             busy,
  output logic                             done
);

  localparam int BL_W = $clog2(MAX_BURST+1);

  state_t state, state_nx;

  logic [DW-1:0] cur_addr, addr_nx;
  logic [DW-1:0] cur_word, word_nx;
  logic          is_write, write_nx;

  logic               t_load, t_zero;
  logic [TIMER_W-1:0] t_val, t_count;

  logic          capture;
  logic          wreq_nx;
  logic          cs_nx, ad_nx, rd_nx, wr_nx, oe_nx;
  logic [DW-1:0] out_nx;

`ifdef BURST_EN
  logic [BL_W-1:0] words_left, left_nx;
`else
  logic unused_burst;
  assign unused_burst = ^{burst_len, t_count};
`endif

  function automatic logic [TIMER_W-1:0] phase_last(input state_t s);
    phase_last = '0;
    case (s)
      ST_ASU:  phase_last = TIMER_W'(T_ASU - 1);
      ST_APW:  phase_last = TIMER_W'(T_APW - 1);
      ST_AH:   phase_last = TIMER_W'(T_AH - 1);
      ST_GAP:  phase_last = TIMER_W'(T_GAP - 1);
      ST_DPW:  phase_last = TIMER_W'(T_DPW - 1);
      ST_DH:   phase_last = TIMER_W'(T_DH - 1);
      default: phase_last = '0;
    endcase
  endfunction

  phase_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .count    (t_count),
    .zero     (t_zero)
  );

  // NOTE: every signal gets a default before the case so no path through
  // this block leaves a value unassigned (which would infer a latch).
  always_comb begin
    state_nx = state;
    addr_nx  = cur_addr;
    word_nx  = cur_word;
    write_nx = is_write;
`ifdef BURST_EN
    left_nx  = words_left;
`endif
    case (state)
      ST_IDLE: if (start) begin
        state_nx = ST_ASU;
        addr_nx  = addr;
        word_nx  = wdata;
        write_nx = write;
`ifdef BURST_EN
        left_nx  = (burst_len == '0) ? BL_W'(1) : burst_len;
`endif
      end
      ST_ASU:  if (t_zero) state_nx = ST_APW;
      ST_APW:  if (t_zero) state_nx = ST_AH;
      ST_AH:   if (t_zero) state_nx = ST_GAP;
      ST_GAP:  if (t_zero) state_nx = ST_DPW;
      ST_DPW:  if (t_zero) state_nx = ST_DH;
      ST_DH:   if (t_zero) begin
`ifdef BURST_EN
        if (words_left > BL_W'(1)) begin
          state_nx = ST_ASU;
          addr_nx  = cur_addr + DW'(1);
          word_nx  = wdata;
          left_nx  = words_left - BL_W'(1);
        end else begin
          state_nx = ST_DONE;
        end
`else
        state_nx = ST_DONE;
`endif
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;

    t_load  = (state_nx != state);
    t_val   = phase_last(state_nx);
    capture = (state == ST_DPW) && t_zero && !is_write && !abort;

    wreq_nx = 1'b0;
`ifdef BURST_EN
    // Request lands on the final DH cycle so the word is ready at ASU entry.
    wreq_nx = (state_nx == ST_DH) && write_nx && (left_nx > BL_W'(1)) &&
              (t_load ? (T_DH == 1) : (t_count == TIMER_W'(1)));
`endif

    // Outputs are decoded from the next state and registered, so the pins
    // change on the same edge as the state without any combinational path.
    cs_nx  = 1'b1;
    ad_nx  = 1'b1;
    rd_nx  = 1'b1;
    wr_nx  = 1'b1;
    oe_nx  = 1'b0;
    out_nx = '0;
    case (state_nx)
      ST_ASU, ST_AH: begin
        ad_nx  = 1'b0;
        oe_nx  = 1'b1;
        out_nx = addr_nx;
      end
      ST_APW: begin
        cs_nx  = 1'b0;
        ad_nx  = 1'b0;
        wr_nx  = 1'b0;
        oe_nx  = 1'b1;
        out_nx = addr_nx;
      end
      ST_DPW: begin
        cs_nx = 1'b0;
        if (write_nx) begin
          wr_nx  = 1'b0;
          oe_nx  = 1'b1;
          out_nx = word_nx;
        end else begin
          rd_nx = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cur_addr    <= '0;
      cur_word    <= '0;
      is_write    <= 1'b0;
`ifdef BURST_EN
      words_left  <= '0;
`endif
      cs_n        <= 1'b1;
      ad_n        <= 1'b1;
      rd_n        <= 1'b1;
      wr_n        <= 1'b1;
      bus_oe      <= 1'b0;
      bus_out     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      wdata_req   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      cur_addr    <= addr_nx;
      cur_word    <= word_nx;
      is_write    <= write_nx;
`ifdef BURST_EN
      words_left  <= left_nx;
`endif
      cs_n        <= cs_nx;
      ad_n        <= ad_nx;
      rd_n        <= rd_nx;
      wr_n        <= wr_nx;
      bus_oe      <= oe_nx;
      bus_out     <= out_nx;
      if (capture) rdata <= bus_in;
      rdata_valid <= capture;
      wdata_req   <= wreq_nx;
      busy        <= (state_nx != ST_IDLE);
      done        <= (state_nx == ST_DONE);
    end
  end

endmodule
